// File: rtl/par_mult_if.sv
// Parity-protected multiply handshake: the tester side (master) drives the
// operands and req, and the responder side (slave) returns ack and the result.
interface par_mult_if;
  logic [15:0] arg_a;
  logic        arg_a_parity;
  logic [15:0] arg_b;
  logic        arg_b_parity;
  logic        req;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  modport master (
    output arg_a, arg_a_parity, arg_b, arg_b_parity, req,
    input  ack, result, result_parity, result_rdy, arg_parity_error
  );

  modport slave (
    input  arg_a, arg_a_parity, arg_b, arg_b_parity, req,
    output ack, result, result_parity, result_rdy, arg_parity_error
  );
endinterface

// File: rtl/par_mult_responder.sv
// Responder end of the parity-checked multiply handshake: captures operands on
// req, acks, and returns the signed product (or a flagged zero) LATENCY edges later.
module par_mult_responder #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  par_mult_if.slave   bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    ack_nx, rdy_nx, capture, finish;

  logic signed [15:0]      a_p0, b_p0;
  logic                    perr_p0;
  logic                    ack_p0;

  logic signed [31:0]      prod;
  logic signed [31:0]      result_p1;
  logic                    rpar_p1, perr_p1, rdy_p1;

  function automatic logic parity_bad(input logic [15:0] v, input logic p);
    return p != (^v);
  endfunction

  // DONE behaves like IDLE for a held req, so back-to-back captures need no idle cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack_nx   = 1'b0;
    rdy_nx   = 1'b0;
    capture  = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.req) begin
          capture  = 1'b1;
          ack_nx   = 1'b1;
          state_nx = BUSY;
          cnt_nx   = CNT_W'(LATENCY - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        // The ack cycle is not part of the countdown.
        if (ack_p0) begin
          cnt_nx = cnt;
        end else if (cnt == '0) begin
          state_nx = DONE;
          rdy_nx   = 1'b1;
          finish   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Stage p0: operand capture
  always_ff @(posedge clk) begin
    if (capture) begin
      a_p0    <= bus.arg_a;
      b_p0    <= bus.arg_b;
      perr_p0 <= parity_bad(bus.arg_a, bus.arg_a_parity) ||
                 parity_bad(bus.arg_b, bus.arg_b_parity);
    end
  end

  always_comb begin
    prod = $signed({{16{a_p0[15]}}, a_p0}) * $signed({{16{b_p0[15]}}, b_p0});
    if (perr_p0) prod = '0;
  end

  // Stage p1: result registers, updated only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_p0    <= 1'b0;
      rdy_p1    <= 1'b0;
      result_p1 <= '0;
      rpar_p1   <= 1'b0;
      perr_p1   <= 1'b0;
    end else begin
      ack_p0 <= ack_nx;
      rdy_p1 <= rdy_nx;
      if (finish) begin
        result_p1 <= prod;
        rpar_p1   <= ^prod;
        perr_p1   <= perr_p0;
      end
    end
  end

  assign bus.ack              = ack_p0;
  assign bus.result_rdy       = rdy_p1;
  assign bus.result           = result_p1;
  assign bus.result_parity    = rpar_p1;
  assign bus.arg_parity_error = perr_p1;

endmodule

// File: tb/tb_par_mult_responder.sv
// Bench for par_mult_responder: directed scenarios plus a randomized soak
// checked against an arithmetic reference model.
module tb_par_mult_responder;

  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  par_mult_if bus();

  par_mult_responder #(.LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          to;
    int          ack_w;
    int          lat;
    int          rdy_w;
    bit          overlap;
    logic [31:0] res;
    logic        rp;
    logic        pe;
    logic [31:0] res_hold;
  } obs_t;

  // Reference model: plain signed arithmetic on the captured values.
  function automatic logic model_err(input logic [15:0] a, b, input logic pa, pb);
    return (pa != (^a)) || (pb != (^b));
  endfunction

  function automatic logic [31:0] model_res(input logic [15:0] a, b, input logic pa, pb);
    longint p;
    if (model_err(a, b, pa, pb)) return 32'h0;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [15:0] a, b, input logic pa, pb);
    bus.arg_a = a; bus.arg_b = b; bus.arg_a_parity = pa; bus.arg_b_parity = pb;
  endtask

  // Runs one request and records what the responder did; scrambles the operands after capture.
  task automatic do_txn(input logic [15:0] a, b, input logic pa, pb, output obs_t o);
    int k;
    o = '{default: 0};
    o.lat = -1;
    o.to = 1'b1;
    drive_ops(a, b, pa, pb);
    bus.req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.ack) begin o.to = 1'b0; break; end
    end
    bus.req = 1'b0;
    if (o.to) return;
    drive_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    k = 0;
    while (k < 40) begin
      if (bus.ack) o.ack_w++;
      if (bus.ack && bus.result_rdy) o.overlap = 1'b1;
      if (bus.result_rdy) begin
        if (o.lat < 0) begin
          o.lat = k;
          o.res = bus.result;
          o.rp  = bus.result_parity;
          o.pe  = bus.arg_parity_error;
        end
        o.rdy_w++;
      end else if (o.lat >= 0) begin
        break;
      end
      step();
      k++;
    end
    if (o.lat < 0) o.to = 1'b1;
    o.res_hold = bus.result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 1'b0;
    drive_ops(16'h0, 16'h0, 1'b0, 1'b0);
    step(); step();
    total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.ack); end
    total++; if (bus.result_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.result_rdy); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.result_parity !== 1'b0) begin bad++; $display("FAIL reset_rpar got=%b want=0", bus.result_parity); end
    total++; if (bus.arg_parity_error !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus.arg_parity_error); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    obs_t o;
    do_txn(16'd3, 16'hFFFE, ^16'd3, ^16'hFFFE, o);
    total++;
    if (o.to) begin bad++; $display("FAIL basic_timeout got=timeout want=response"); return; end
    total++; if (o.ack_w !== 1) begin bad++; $display("FAIL basic_ack_width got=%0d want=1", o.ack_w); end
    total++; if (o.lat !== L + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", o.lat, L + 1); end
    total++; if (o.res !== 32'hFFFF_FFFA) begin bad++; $display("FAIL basic_result got=%h want=fffffffa", o.res); end
    total++; if (o.rp !== 1'b0 || o.pe !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b want=00", o.rp, o.pe); end
    total++; if (o.rdy_w !== 1) begin bad++; $display("FAIL basic_rdy_width got=%0d want=1", o.rdy_w); end
  endtask

  task automatic test_corners();
    logic [15:0] av [3] = '{16'h7FFF, 16'h8000, 16'h0000};
    logic [15:0] bv [3] = '{16'h7FFF, 16'h8000, 16'h00FF};
    logic [31:0] rv [3] = '{32'h3FFF_0001, 32'h4000_0000, 32'h0};
    logic        pv [3] = '{1'b1, 1'b1, 1'b0};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      do_txn(av[i], bv[i], ^av[i], ^bv[i], o);
      total++;
      if (o.to || o.res !== rv[i] || o.rp !== pv[i] || o.pe !== 1'b0)
        begin bad++; $display("FAIL corner%0d got=%h/%b/%b to=%b want=%h/%b/0", i, o.res, o.rp, o.pe, o.to, rv[i], pv[i]); end
    end
  endtask

  task automatic test_parity_err();
    obs_t o;
    do_txn(16'd5, 16'd7, 1'b1, ^16'd7, o);
    total++;
    if (o.to || o.lat !== L + 1) begin bad++; $display("FAIL perr_latency got=%0d to=%b want=%0d", o.lat, o.to, L + 1); end
    total++;
    if (o.res !== 32'h0 || o.rp !== 1'b0 || o.pe !== 1'b1)
      begin bad++; $display("FAIL perr_fields got=%h/%b/%b want=00000000/0/1", o.res, o.rp, o.pe); end
  endtask

  task automatic test_held_req();
    int c0, c1;
    bit seen;
    drive_ops(16'd100, 16'hFFF6, ^16'd100, ^16'hFFF6);
    bus.req = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.ack) begin seen = 1; break; end end
    c0 = cyc;
    drive_ops(16'd9, 16'd11, ^16'd9, ^16'd11);
    total++; if (!seen) begin bad++; $display("FAIL held_ack1 got=none want=ack"); bus.req = 1'b0; return; end
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.result_rdy) begin seen = 1; break; end end
    total++;
    if (!seen || bus.result !== 32'hFFFF_FC18)
      begin bad++; $display("FAIL held_result1 got=%h seen=%b want=fffffc18", bus.result, seen); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ack) begin seen = 1; break; end
      step();
    end
    c1 = cyc;
    bus.req = 1'b0;
    total++;
    if (!seen || c1 - c0 !== L + 2) begin bad++; $display("FAIL held_ack2_edge got=%0d want=%0d", c1 - c0, L + 2); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.result_rdy) begin seen = 1; break; end end
    total++;
    if (!seen || bus.result !== 32'd99) begin bad++; $display("FAIL held_result2 got=%h want=00000063", bus.result); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit seen;
    bit rdy_seen;
    drive_ops(16'd21, 16'd2, ^16'd21, ^16'd2);
    bus.req = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.ack) begin seen = 1; break; end end
    bus.req = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL rstmid_ack got=none want=ack"); end
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.ack !== 1'b0 || bus.result_rdy !== 1'b0 || bus.result !== 32'h0 ||
        bus.result_parity !== 1'b0 || bus.arg_parity_error !== 1'b0)
      begin bad++; $display("FAIL rstmid_outputs got=%b%b%h%b%b want=all zero", bus.ack, bus.result_rdy,
                             bus.result, bus.result_parity, bus.arg_parity_error); end
    step();
    rst_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin step(); if (bus.result_rdy || bus.ack) rdy_seen = 1; end
    total++; if (rdy_seen) begin bad++; $display("FAIL rstmid_no_rdy got=pulse want=none"); end
    do_txn(16'hFFFF, 16'hFFFF, ^16'hFFFF, ^16'hFFFF, o);
    total++;
    if (o.to || o.res !== 32'd1 || o.lat !== L + 1)
      begin bad++; $display("FAIL rstmid_recover got=%h lat=%0d want=00000001 lat=%0d", o.res, o.lat, L + 1); end
  endtask

  task automatic test_soak();
    obs_t o;
    logic [15:0] a, b;
    logic pa, pb;
    logic [31:0] er;
    int nerr;
    nerr = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom); b = 16'($urandom);
      pa = ^a; pb = ^b;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: pa = ~pa;
          1: pb = ~pb;
          default: begin pa = ~pa; pb = ~pb; end
        endcase
        nerr++;
      end
      er = model_res(a, b, pa, pb);
      do_txn(a, b, pa, pb, o);
      total++;
      if (o.to) begin bad++; $display("FAIL soak%0d timeout got=none want=result", n); continue; end
      total++;
      if (o.res !== er || o.rp !== (^er) || o.pe !== model_err(a, b, pa, pb))
        begin bad++; $display("FAIL soak%0d fields a=%h b=%h got=%h/%b/%b want=%h/%b/%b", n, a, b,
                              o.res, o.rp, o.pe, er, ^er, model_err(a, b, pa, pb)); end
      total++;
      if (o.ack_w !== 1 || o.rdy_w !== 1 || o.lat !== L + 1 || o.overlap)
        begin bad++; $display("FAIL soak%0d timing got=ack%0d rdy%0d lat%0d ov%b want=1 1 %0d 0", n,
                              o.ack_w, o.rdy_w, o.lat, o.overlap, L + 1); end
      total++;
      if (o.res_hold !== er) begin bad++; $display("FAIL soak%0d hold got=%h want=%h", n, o.res_hold, er); end
    end
    total++;
    if (nerr == 0) begin bad++; $display("FAIL soak_parity_mix got=0 want=nonzero"); end
  endtask

  initial begin
    bus.req = 1'b0;
    drive_ops(16'h0, 16'h0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_corners();
    test_parity_err();
    test_held_req();
    test_reset_mid();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
